// File: rtl/cv32e40x_pkg.sv
// Types and helpers for the shared divider arbiter: divide op encoding, arbiter FSM
// states, latched request payload and the div_op -> ALU opcode mapping.
package cv32e40x_pkg;

  localparam int unsigned DIV_DATA_W = 32;
  localparam int unsigned DIV_OP_W   = 2;
  localparam int unsigned ALU_OP_W   = 6;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_DIVU = 6'h1C,
    ALU_DIV  = 6'h1D,
    ALU_REMU = 6'h1E,
    ALU_REM  = 6'h1F
  } alu_opcode_e;

  typedef enum logic [DIV_OP_W-1:0] {
    DIV_DIVU = 2'b00,
    DIV_DIV  = 2'b01,
    DIV_REMU = 2'b10,
    DIV_REM  = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    RESP = 2'b10
  } div_arb_state_e;

  // Operands captured from the winning requester
  typedef struct packed {
    div_op_e                 op;
    logic [DIV_DATA_W-1:0]   opa;
    logic [DIV_DATA_W-1:0]   opb;
  } div_req_t;

  function automatic alu_opcode_e div_op_to_alu(input div_op_e op);
    alu_opcode_e alu_op;
    alu_op = ALU_DIVU;
    case (op)
      DIV_DIVU: alu_op = ALU_DIVU;
      DIV_DIV:  alu_op = ALU_DIV;
      DIV_REMU: alu_op = ALU_REMU;
      DIV_REM:  alu_op = ALU_REM;
      default:  alu_op = ALU_DIVU;
    endcase
    return alu_op;
  endfunction

endpackage

// File: rtl/cv32e40x_rr_arbiter.sv
// Combinational round-robin picker: grants the first requester at or after ptr,
// wrapping around, as a one-hot vector plus its index.
module cv32e40x_rr_arbiter
  import cv32e40x_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx
);

  logic found;

  function automatic int unsigned wrap_idx(input int unsigned base, input int unsigned offs);
    int unsigned sum;
    sum = base + offs;
    return (sum >= NUM_REQ) ? (sum - NUM_REQ) : sum;
  endfunction

  // Scan from the pointer, first hit wins
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!found && req[wrap_idx(32'(ptr), k)]) begin
        found                       = 1'b1;
        gnt[wrap_idx(32'(ptr), k)]  = 1'b1;
        gnt_idx                     = IDX_W'(wrap_idx(32'(ptr), k));
      end
    end
  end

endmodule

// File: rtl/cv32e40x_div_arbiter.sv
// Shares one iterative divider between NUM_REQ requesters: round-robin grant,
// operand latching, result return to the owner and per-requester kill.
module cv32e40x_div_arbiter
  import cv32e40x_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               req_valid_i,
  output logic [NUM_REQ-1:0]               req_ready_o,
  input  logic [NUM_REQ*DIV_OP_W-1:0]      req_op_i,
  input  logic [NUM_REQ*DIV_DATA_W-1:0]    req_opa_i,
  input  logic [NUM_REQ*DIV_DATA_W-1:0]    req_opb_i,
  input  logic [NUM_REQ-1:0]               kill_i,
  output logic [NUM_REQ-1:0]               rsp_valid_o,
  input  logic [NUM_REQ-1:0]               rsp_ready_i,
  output logic [DIV_DATA_W-1:0]            rsp_result_o,
  output logic                             div_valid_o,
  output alu_opcode_e                      div_operator_o,
  output logic [DIV_DATA_W-1:0]            div_opa_o,
  output logic [DIV_DATA_W-1:0]            div_opb_o,
  input  logic                             div_ready_i,
  input  logic [DIV_DATA_W-1:0]            div_result_i,
  output logic                             div_ack_o
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  div_arb_state_e        state_q, state_d;
  logic [IDX_W-1:0]      ptr_q, ptr_d;
  logic [IDX_W-1:0]      owner_q, owner_d;
  logic                  discard_q, discard_d;
  div_req_t              req_q, req_d;
  logic [DIV_DATA_W-1:0] result_q, result_d;
  logic [NUM_REQ-1:0]    rsp_valid_q;
  logic                  div_valid_q;

  logic [NUM_REQ-1:0]    eligible;
  logic [NUM_REQ-1:0]    grant;
  logic [IDX_W-1:0]      grant_idx;
  div_req_t              grant_req;
  logic [IDX_W-1:0]      owner_nxt;
  logic                  owner_kill;
  logic                  owner_rsp_ready;

  assign eligible        = req_valid_i & ~kill_i;
  assign owner_kill      = kill_i[owner_q];
  assign owner_rsp_ready = rsp_ready_i[owner_q];
  assign owner_nxt       = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + IDX_W'(1);

  cv32e40x_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .req     (eligible),
    .ptr     (ptr_q),
    .gnt     (grant),
    .gnt_idx (grant_idx)
  );

  // Operand mux for the granted requester
  always_comb begin
    grant_req = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        grant_req.op  = div_op_e'(req_op_i[i*DIV_OP_W +: DIV_OP_W]);
        grant_req.opa = req_opa_i[i*DIV_DATA_W +: DIV_DATA_W];
        grant_req.opb = req_opb_i[i*DIV_DATA_W +: DIV_DATA_W];
      end
    end
  end

  // Next-state and handshake logic
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    discard_d   = discard_q;
    req_d       = req_q;
    result_d    = result_q;
    req_ready_o = '0;
    div_ack_o   = 1'b0;

    case (state_q)
      IDLE: begin
        if (|grant) begin
          req_ready_o = grant;
          owner_d     = grant_idx;
          req_d       = grant_req;
          discard_d   = 1'b0;
          state_d     = BUSY;
        end
      end

      BUSY: begin
        if (owner_kill) begin
          discard_d = 1'b1;
        end
        if (div_ready_i) begin
          div_ack_o = 1'b1;
          if (discard_q || owner_kill) begin
            // Drained result of a killed op is dropped; move on fairly
            discard_d = 1'b0;
            ptr_d     = owner_nxt;
            state_d   = IDLE;
          end else begin
            result_d  = div_result_i;
            state_d   = RESP;
          end
        end
      end

      RESP: begin
        if (owner_kill || owner_rsp_ready) begin
          ptr_d   = owner_nxt;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      discard_q   <= 1'b0;
      req_q       <= '0;
      result_q    <= '0;
      rsp_valid_q <= '0;
      div_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      discard_q   <= discard_d;
      req_q       <= req_d;
      result_q    <= result_d;
      rsp_valid_q <= (state_d == RESP) ? (NUM_REQ'(1) << owner_d) : '0;
      div_valid_q <= (state_d == BUSY);
    end
  end

  assign rsp_valid_o    = rsp_valid_q;
  assign rsp_result_o   = result_q;
  assign div_valid_o    = div_valid_q;
  assign div_operator_o = div_op_to_alu(req_q.op);
  assign div_opa_o      = req_q.opa;
  assign div_opb_o      = req_q.opb;

endmodule
